// File: rtl/i2c_pkg.sv
// Shared I2C command definitions: command codes, command word layout and sequencer states.
// Used by the host decode, the command queue and the master byte engine.
package i2c_pkg;

  localparam int unsigned WORD_W  = 16;
  localparam int unsigned CODE_W  = 4;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned CODE_LSB = 8;

  typedef enum logic [CODE_W-1:0] {
    CMD_NOP          = 4'h0,
    CMD_READ         = 4'h1,
    CMD_WRITE        = 4'h2,
    CMD_WRITE_MULTI  = 4'h3,
    CMD_START        = 4'h4,
    CMD_STOP         = 4'h5,
    CMD_SET_ADDR     = 4'hB,
    CMD_SET_SCL_L    = 4'hC,
    CMD_SET_SCL_H    = 4'hD,
    CMD_STOP_ON_IDLE = 4'hE,
    CMD_RESET        = 4'hF
  } cmd_code_e;

  // Host command word: {flags[15:12], cmd[11:8], data[7:0]}, flags[12] = last
  typedef struct packed {
    logic [2:0]        rsvd;
    logic              last;
    cmd_code_e         code;
    logic [DATA_W-1:0] data;
  } cmd_word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_POP   = 2'd1,
    ST_ISSUE = 2'd2,
    ST_WAIT  = 2'd3
  } seq_state_e;

  // NOP is discarded and RESET acts as flush; neither occupies a FIFO slot
  function automatic logic cmd_is_queued(input cmd_code_e c);
    return (c != CMD_NOP) && (c != CMD_RESET);
  endfunction

endpackage

// File: rtl/i2c_cmd_queue_if.sv
// Host-write, master-command and status signals of the I2C command queue.
// slave = queue side, master = host/engine side.
interface i2c_cmd_queue_if #(
  parameter int unsigned AW = 4
);
  import i2c_pkg::*;

  logic              wr_en;
  logic [WORD_W-1:0] wr_data;
  logic              full;
  logic [AW:0]       level;
  logic              overflow;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [CODE_W-1:0] cmd_code;
  logic [DATA_W-1:0] cmd_data;
  logic              cmd_last;
  logic              master_done;
  logic [DATA_W-1:0] master_rdata;
  logic [DATA_W-1:0] rd_byte;
  logic              rd_valid;
  logic              rd_ack;
  logic              busy;
  logic              irq;
  logic              irq_ack;

  modport slave (
    input  wr_en, wr_data, cmd_ready, master_done, master_rdata, rd_ack, irq_ack,
    output full, level, overflow, cmd_valid, cmd_code, cmd_data, cmd_last,
           rd_byte, rd_valid, busy, irq
  );

  modport master (
    output wr_en, wr_data, cmd_ready, master_done, master_rdata, rd_ack, irq_ack,
    input  full, level, overflow, cmd_valid, cmd_code, cmd_data, cmd_last,
           rd_byte, rd_valid, busy, irq
  );

endinterface

// File: rtl/i2c_cmd_fifo.sv
// Synchronous command FIFO with registered level/full/empty and a flush input.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module i2c_cmd_fifo
  import i2c_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] dout,
  output logic [AW:0]       level,
  output logic              full,
  output logic              empty,
  output logic              empty_next_c
);

  localparam int unsigned PW = AW + 1;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr_d;
  logic [PW-1:0]     rd_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr + PW'(push);
    rd_ptr_d = rd_ptr + PW'(pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  assign empty_next_c = (wr_ptr_d == rd_ptr_d);
  assign dout         = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge sysclk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr_d;
      rd_ptr <= rd_ptr_d;
      level  <= wr_ptr_d - rd_ptr_d;
      full   <= (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
      empty  <= empty_next_c;
    end
  end

endmodule

// File: rtl/i2c_cmd_queue.sv
// I2C command queue: buffers host command words and issues them to the master
// one at a time, capturing read data and raising irq on "last" completion.
module i2c_cmd_queue
  import i2c_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input logic             sysclk,
  input logic             reset,
  i2c_cmd_queue_if.slave  bus
);

  cmd_code_e         wr_code;
  logic              flush;
  logic              queued;
  logic              push;
  logic              drop;
  logic              pop;
  logic              finish;
  logic [WORD_W-1:0] fifo_dout;
  logic [AW:0]       fifo_level;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_empty_next;
  cmd_word_t         head;
  logic              unused_rsvd;

  seq_state_e        state;
  seq_state_e        state_d;
  logic              valid;
  cmd_code_e         code;
  logic [DATA_W-1:0] data;
  logic              last;
  logic [DATA_W-1:0] rd_byte;
  logic              rd_valid;
  logic              irq;
  logic              busy;
  logic              overflow;

  // Host write decode; fullness is judged before any same-cycle pop
  assign wr_code = cmd_code_e'(bus.wr_data[CODE_LSB +: CODE_W]);
  assign flush   = bus.wr_en && (wr_code == CMD_RESET);
  assign queued  = bus.wr_en && cmd_is_queued(wr_code);
  assign push    = queued && !fifo_full;
  assign drop    = queued && fifo_full;
  assign pop     = (state == ST_POP) && !flush;
  assign finish  = (state == ST_WAIT) && bus.master_done && !flush;

  assign head        = cmd_word_t'(fifo_dout);
  assign unused_rsvd = ^head.rsvd;

  i2c_cmd_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .sysclk       (sysclk),
    .reset        (reset),
    .push         (push),
    .pop          (pop),
    .flush        (flush),
    .din          (bus.wr_data),
    .dout         (fifo_dout),
    .level        (fifo_level),
    .full         (fifo_full),
    .empty        (fifo_empty),
    .empty_next_c (fifo_empty_next)
  );

  always_comb begin
    state_d = state;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (!fifo_empty) state_d = ST_POP;
        ST_POP:   state_d = ST_ISSUE;
        ST_ISSUE: if (bus.cmd_ready) state_d = ST_WAIT;
        ST_WAIT:  if (bus.master_done) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Sequencer state plus registered command, capture and status outputs
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state    <= ST_IDLE;
      valid    <= 1'b0;
      code     <= CMD_NOP;
      data     <= '0;
      last     <= 1'b0;
      rd_byte  <= '0;
      rd_valid <= 1'b0;
      irq      <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_d;
      busy  <= !fifo_empty_next || (state_d != ST_IDLE);
      if (flush) begin
        valid    <= 1'b0;
        overflow <= 1'b0;
        rd_valid <= 1'b0;
        irq      <= 1'b0;
      end else begin
        if (drop) overflow <= 1'b1;
        if (state == ST_POP) begin
          valid <= 1'b1;
          code  <= head.code;
          data  <= head.data;
          last  <= head.last;
        end else if ((state == ST_ISSUE) && bus.cmd_ready) begin
          valid <= 1'b0;
        end
        if (finish && (code == CMD_READ)) begin
          rd_byte  <= bus.master_rdata;
          rd_valid <= 1'b1;
        end else if (bus.rd_ack) begin
          rd_valid <= 1'b0;
        end
        if (finish && last) irq <= 1'b1;
        else if (bus.irq_ack) irq <= 1'b0;
      end
    end
  end

  assign bus.full      = fifo_full;
  assign bus.level     = fifo_level;
  assign bus.overflow  = overflow;
  assign bus.cmd_valid = valid;
  assign bus.cmd_code  = code;
  assign bus.cmd_data  = data;
  assign bus.cmd_last  = last;
  assign bus.rd_byte   = rd_byte;
  assign bus.rd_valid  = rd_valid;
  assign bus.busy      = busy;
  assign bus.irq       = irq;

endmodule

// File: tb/tb_i2c_cmd_queue.sv
// Directed bench for i2c_cmd_queue: ordering, last/irq, read capture, overflow,
// flush and simultaneous set/clear behaviour, all against hand-computed values.
module tb_i2c_cmd_queue;
  import i2c_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic sysclk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  i2c_cmd_queue_if #(.AW(AW)) bus ();

  i2c_cmd_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 sysclk = ~sysclk;

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write(input logic [15:0] word);
    bus.wr_en   = 1'b1;
    bus.wr_data = word;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  // Wait (bounded) for a command, check it, then accept it
  task automatic issue_expect(input string tag, input logic [3:0] c, input logic [7:0] d,
                              input logic l);
    int n;
    n = 0;
    while ((bus.cmd_valid !== 1'b1) && (n < 8)) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 16'(bus.cmd_valid), 16'd1);
    check({tag, "_code"},  16'(bus.cmd_code),  16'(c));
    check({tag, "_data"},  16'(bus.cmd_data),  16'(d));
    check({tag, "_last"},  16'(bus.cmd_last),  16'(l));
    bus.cmd_ready = 1'b1;
    tick();
    bus.cmd_ready = 1'b0;
    check({tag, "_accepted"}, 16'(bus.cmd_valid), 16'd0);
  endtask

  task automatic complete(input logic [7:0] rdata);
    bus.master_done  = 1'b1;
    bus.master_rdata = rdata;
    tick();
    bus.master_done  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset            = 1'b1;
    bus.wr_en        = 1'b0;
    bus.wr_data      = '0;
    bus.cmd_ready    = 1'b0;
    bus.master_done  = 1'b0;
    bus.master_rdata = '0;
    bus.rd_ack       = 1'b0;
    bus.irq_ack      = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_level",    16'(bus.level),     16'd0);
    check("rst_full",     16'(bus.full),      16'd0);
    check("rst_overflow", 16'(bus.overflow),  16'd0);
    check("rst_valid",    16'(bus.cmd_valid), 16'd0);
    check("rst_code",     16'(bus.cmd_code),  16'd0);
    check("rst_data",     16'(bus.cmd_data),  16'd0);
    check("rst_last",     16'(bus.cmd_last),  16'd0);
    check("rst_rd_byte",  16'(bus.rd_byte),   16'd0);
    check("rst_rd_valid", 16'(bus.rd_valid),  16'd0);
    check("rst_busy",     16'(bus.busy),      16'd0);
    check("rst_irq",      16'(bus.irq),       16'd0);
    reset = 1'b0;
    tick();

    // In-order issue of three commands, one per master_done
    write(16'h0D00);
    check("t1_level1", 16'(bus.level),     16'd1);
    check("t1_busy",   16'(bus.busy),      16'd1);
    check("t1_valid0", 16'(bus.cmd_valid), 16'd0);
    write(16'h0C11);
    check("t1_level2", 16'(bus.level), 16'd2);
    write(16'h0B72);
    check("t1_valid_n2", 16'(bus.cmd_valid), 16'd1);
    check("t1_level_n2", 16'(bus.level),     16'd2);
    issue_expect("t1_a", 4'hD, 8'h00, 1'b0);
    complete(8'h00);
    check("t1_irq_a",   16'(bus.irq),       16'd0);
    check("t1_gap_m0",  16'(bus.cmd_valid), 16'd0);
    tick();
    check("t1_gap_m1",  16'(bus.cmd_valid), 16'd0);
    tick();
    check("t1_gap_m2",  16'(bus.cmd_valid), 16'd1);
    issue_expect("t1_b", 4'hC, 8'h11, 1'b0);
    complete(8'h00);
    issue_expect("t1_c", 4'hB, 8'h72, 1'b0);
    complete(8'h00);
    check("t1_irq_end",  16'(bus.irq),   16'd0);
    check("t1_busy_end", 16'(bus.busy),  16'd0);
    check("t1_level_end",16'(bus.level), 16'd0);

    // Multi-byte write with last flag on the final byte
    write(16'h031E);
    write(16'h03BB);
    write(16'h1327);
    issue_expect("t2_a", 4'h3, 8'h1E, 1'b0);
    complete(8'h00);
    issue_expect("t2_b", 4'h3, 8'hBB, 1'b0);
    complete(8'h00);
    check("t2_irq_pre", 16'(bus.irq), 16'd0);
    issue_expect("t2_c", 4'h3, 8'h27, 1'b1);
    complete(8'h00);
    check("t2_irq",      16'(bus.irq),      16'd1);
    check("t2_rd_valid", 16'(bus.rd_valid), 16'd0);
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    check("t2_irq_ack", 16'(bus.irq), 16'd0);

    // Read capture; rd_ack clears rd_valid only (irq left set for the flush test)
    write(16'h1100);
    issue_expect("t3", 4'h1, 8'h00, 1'b1);
    complete(8'hA5);
    check("t3_rd_byte",  16'(bus.rd_byte),  16'h00A5);
    check("t3_rd_valid", 16'(bus.rd_valid), 16'd1);
    check("t3_irq",      16'(bus.irq),      16'd1);
    bus.rd_ack = 1'b1;
    tick();
    bus.rd_ack = 1'b0;
    check("t3_ack_valid", 16'(bus.rd_valid), 16'd0);
    check("t3_ack_byte",  16'(bus.rd_byte),  16'h00A5);
    check("t3_ack_irq",   16'(bus.irq),      16'd1);

    // Overflow with cmd_ready held low: DEPTH+1 accepted, the last word dropped
    for (int i = 0; i < 16; i++) write(16'h0200 | 16'(i));
    check("t4_full16",  16'(bus.full),  16'd0);
    check("t4_level16", 16'(bus.level), 16'd15);
    write(16'h0210);
    check("t4_full17",  16'(bus.full),     16'd1);
    check("t4_level17", 16'(bus.level),    16'd16);
    check("t4_ovf17",   16'(bus.overflow), 16'd0);
    write(16'h0211);
    check("t4_full18",  16'(bus.full),     16'd1);
    check("t4_level18", 16'(bus.level),    16'd16);
    check("t4_ovf18",   16'(bus.overflow), 16'd1);
    for (int k = 0; k < 17; k++) begin
      issue_expect("t4_drain", 4'h2, 8'(k), 1'b0);
      complete(8'h00);
    end
    repeat (4) tick();
    check("t4_no_extra", 16'(bus.cmd_valid), 16'd0);
    check("t4_level0",   16'(bus.level),     16'd0);
    check("t4_busy0",    16'(bus.busy),      16'd0);
    check("t4_ovf_held", 16'(bus.overflow),  16'd1);

    // Flush during WAIT abandons the outstanding READ
    write(16'h1100);
    write(16'h0233);
    write(16'h0244);
    issue_expect("t5", 4'h1, 8'h00, 1'b1);
    check("t5_level_pre", 16'(bus.level), 16'd2);
    write(16'h0F00);
    check("t5_level",    16'(bus.level),     16'd0);
    check("t5_full",     16'(bus.full),      16'd0);
    check("t5_valid",    16'(bus.cmd_valid), 16'd0);
    check("t5_busy",     16'(bus.busy),      16'd0);
    check("t5_overflow", 16'(bus.overflow),  16'd0);
    check("t5_irq",      16'(bus.irq),       16'd0);
    complete(8'h5A);
    check("t5_late_irq",   16'(bus.irq),      16'd0);
    check("t5_late_valid", 16'(bus.rd_valid), 16'd0);
    check("t5_late_byte",  16'(bus.rd_byte),  16'h00A5);
    repeat (3) tick();
    check("t5_idle_valid", 16'(bus.cmd_valid), 16'd0);
    check("t5_idle_busy",  16'(bus.busy),      16'd0);

    // NOP discarded; same-cycle set beats clear for irq and rd_valid
    write(16'h0000);
    check("t6_nop_level", 16'(bus.level), 16'd0);
    check("t6_nop_busy",  16'(bus.busy),  16'd0);
    tick();
    check("t6_nop_valid", 16'(bus.cmd_valid), 16'd0);
    write(16'h1100);
    issue_expect("t6_a", 4'h1, 8'h00, 1'b1);
    complete(8'h11);
    check("t6_a_byte", 16'(bus.rd_byte), 16'h0011);
    check("t6_a_irq",  16'(bus.irq),     16'd1);
    write(16'h1100);
    issue_expect("t6_b", 4'h1, 8'h00, 1'b1);
    bus.rd_ack  = 1'b1;
    bus.irq_ack = 1'b1;
    complete(8'h3C);
    bus.rd_ack  = 1'b0;
    bus.irq_ack = 1'b0;
    check("t6_set_irq",   16'(bus.irq),      16'd1);
    check("t6_set_valid", 16'(bus.rd_valid), 16'd1);
    check("t6_set_byte",  16'(bus.rd_byte),  16'h003C);
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    check("t6_irq_clr", 16'(bus.irq), 16'd0);
    bus.rd_ack = 1'b1;
    tick();
    bus.rd_ack = 1'b0;
    check("t6_valid_clr", 16'(bus.rd_valid), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
